// File: rtl/pattern_tx.sv
// Serial pattern transmitter: shifts a captured frame out MSB-of-frame first,
// repeating it Rep extra times with a one-cycle low gap between repetitions.
module pattern_tx #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Load,
    input  logic [WIDTH-1:0] Data,
    input  logic [2:0]       Len,
    input  logic [3:0]       Rep,
    output logic             Out1,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] data_r;
    logic [2:0]       len_r;
    logic [3:0]       rep_r;
    logic [2:0]       bit_cnt;
    logic [3:0]       rep_cnt;
    logic [2:0]       nxt_idx;

    // Index of the bit that follows the one currently on Out1.
    always_comb begin
        nxt_idx = len_r - bit_cnt - 3'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state   <= IDLE;
            data_r  <= '0;
            len_r   <= '0;
            rep_r   <= '0;
            bit_cnt <= '0;
            rep_cnt <= '0;
            Out1    <= 1'b0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    Done <= 1'b0;
                    if (Load) begin
                        data_r  <= Data;
                        len_r   <= Len;
                        rep_r   <= Rep;
                        bit_cnt <= '0;
                        rep_cnt <= '0;
                        Out1    <= Data[Len];
                        Busy    <= 1'b1;
                        state   <= SHIFT;
                    end else begin
                        Out1  <= 1'b0;
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    if (bit_cnt < len_r) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        Out1    <= data_r[nxt_idx];
                    end else if (rep_cnt < rep_r) begin
                        rep_cnt <= rep_cnt + 4'd1;
                        Out1    <= 1'b0;
                        state   <= GAP;
                    end else begin
                        Out1  <= 1'b0;
                        Busy  <= 1'b0;
                        Done  <= 1'b1;
                        state <= DONE;
                    end
                end
                GAP: begin
                    bit_cnt <= '0;
                    Out1    <= data_r[len_r];
                    state   <= SHIFT;
                end
                default: begin
                    Out1  <= 1'b0;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pattern_tx.sv
// Directed bench for pattern_tx; outputs are sampled 1 time unit after each
// rising edge, and inputs are changed at that same point.
module tb_pattern_tx;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       Load = 1'b0;
    logic [7:0] Data = 8'h00;
    logic [2:0] Len = 3'd0;
    logic [3:0] Rep = 4'd0;
    logic       Out1, Busy, Done;

    int total = 0;
    int bad = 0;

    pattern_tx #(.WIDTH(8)) dut (
        .CLK(CLK), .RST(RST), .Load(Load), .Data(Data), .Len(Len), .Rep(Rep),
        .Out1(Out1), .Busy(Busy), .Done(Done)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk3(input string tag, input logic o, input logic b, input logic d);
        chk({tag, ".Out1"}, {31'd0, Out1}, {31'd0, o});
        chk({tag, ".Busy"}, {31'd0, Busy}, {31'd0, b});
        chk({tag, ".Done"}, {31'd0, Done}, {31'd0, d});
    endtask

    initial begin
        logic [7:0] pat;
        logic [7:0] gap_seq;
        int dones;
        int busy_cnt;
        int dcnt;

        // reset state
        step(); step();
        chk3("reset", 1'b0, 1'b0, 1'b0);
        RST = 1'b0;
        step();
        chk3("idle", 1'b0, 1'b0, 1'b0);

        // 2-bit frame, single shot
        Data = 8'h02; Len = 3'd1; Rep = 4'd0; Load = 1'b1;
        step(); Load = 1'b0;
        chk3("f02.b1", 1'b1, 1'b1, 1'b0);
        step();
        chk3("f02.b0", 1'b0, 1'b1, 1'b0);
        step();
        chk3("f02.done", 1'b0, 1'b0, 1'b1);
        step();
        chk3("f02.idle", 1'b0, 1'b0, 1'b0);

        // full 8-bit frame, with Load/Data/Len/Rep disturbed while shifting
        Data = 8'hA5; Len = 3'd7; Rep = 4'd0; Load = 1'b1;
        step();
        Data = 8'hFF; Len = 3'd0; Rep = 4'd3;
        pat = 8'b1010_0101;
        dones = 0;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("fA5.bit%0d", k), {31'd0, Out1}, {31'd0, pat[7-k]});
            chk($sformatf("fA5.busy%0d", k), {31'd0, Busy}, 32'd1);
            if (Done) dones++;
            if (k == 7) Load = 1'b0;
            step();
        end
        chk3("fA5.done", 1'b0, 1'b0, 1'b1);
        dones++;
        step();
        if (Done) dones++;
        chk("fA5.done_count", dones, 32'd1);
        chk3("fA5.idle", 1'b0, 1'b0, 1'b0);

        // repeated frame with gaps: 1,0,gap,1,0,gap,1,0
        Data = 8'h02; Len = 3'd1; Rep = 4'd2; Load = 1'b1;
        step(); Load = 1'b0;
        gap_seq = 8'b1001_0010;
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("rep.bit%0d", k), {31'd0, Out1}, {31'd0, gap_seq[7-k]});
            chk($sformatf("rep.busy%0d", k), {31'd0, Busy}, 32'd1);
            chk($sformatf("rep.nodone%0d", k), {31'd0, Done}, 32'd0);
            step();
        end
        chk3("rep.done", 1'b0, 1'b0, 1'b1);
        step();

        // reset mid-frame aborts without Done
        Data = 8'hA5; Len = 3'd7; Rep = 4'd0; Load = 1'b1;
        step(); Load = 1'b0;
        step(); step();
        RST = 1'b1;
        step();
        RST = 1'b0;
        chk3("abort", 1'b0, 1'b0, 1'b0);
        dcnt = 0;
        for (int k = 0; k < 20; k++) begin
            if (Done || Busy || Out1) dcnt++;
            step();
        end
        chk("abort.quiet", dcnt, 32'd0);

        // back-to-back load in the DONE cycle
        Data = 8'h02; Len = 3'd1; Rep = 4'd0; Load = 1'b1;
        step(); Load = 1'b0;
        step(); step();
        chk3("b2b.done1", 1'b0, 1'b0, 1'b1);
        Data = 8'h01; Len = 3'd0; Load = 1'b1;
        step(); Load = 1'b0;
        chk3("b2b.bit", 1'b1, 1'b1, 1'b0);
        step();
        chk3("b2b.done2", 1'b0, 1'b0, 1'b1);
        step();

        // Rep=15 with 1-bit frame: 16 frames, busy for 31 cycles
        Data = 8'h01; Len = 3'd0; Rep = 4'd15; Load = 1'b1;
        step(); Load = 1'b0;
        busy_cnt = 0;
        for (int k = 0; k < 100 && Busy; k++) begin
            busy_cnt++;
            step();
        end
        chk("rep15.busy_cycles", busy_cnt, 32'd31);
        chk("rep15.done", {31'd0, Done}, 32'd1);
        step();

        // reset wins over a simultaneous load
        Data = 8'hFF; Len = 3'd7; Load = 1'b1; RST = 1'b1;
        step();
        Load = 1'b0; RST = 1'b0;
        chk3("rst_vs_load", 1'b0, 1'b0, 1'b0);
        step();
        chk3("rst_vs_load.after", 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
